fetch_ctrl: RTL

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_pkg.sv | 14 +
 rtl/ack_timer.sv | 24 ++
 rtl/fetch_ctrl.sv | 81 ++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    HOLD  = 2'd2,
    ERROR = 2'd3
  } fetch_state_t;

  // Default number of unacknowledged REQ cycles tolerated before ERROR.
  localparam int TIMEOUT_DEF = 16;

endpackage

// File: rtl/ack_timer.sv
// 8-bit clear/increment counter that flags the cycle on which an increment
// would bring the count up to LIMIT.
module ack_timer #(
  parameter int LIMIT = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  logic [7:0] cnt;

  // Count stalled REQ cycles; cleared whenever the fetch is not waiting.
  always_ff @(posedge clk) begin
    if (!reset_n || clr) cnt <= '0;
    else if (inc)        cnt <= cnt + 8'd1;
  end

  // This cycle is the LIMIT-th stalled one: the owner should give up.
  assign expired = inc && (cnt == 8'(LIMIT - 1));

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: requests the word at pc, holds it for the
// consumer, bumps the external program counter on each handshake.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        halt,
  input  logic [15:0] pc,
  output logic        pc_inc,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  output logic [15:0] instr,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic        running,
  output logic        err,
  output logic [15:0] fetch_count
);

  fetch_state_t state, state_nxt;
  logic         in_req, in_hold, hs, tmr_exp;

  assign in_req  = (state == REQ);
  assign in_hold = (state == HOLD);
  assign hs      = in_hold && instr_ready;

  // Timer is held clear outside REQ so every REQ entry starts from zero;
  // an acknowledged cycle does not count as a stall.
  ack_timer #(.LIMIT(TIMEOUT)) u_tmr (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (!in_req),
    .inc     (in_req && !mem_ack),
    .expired (tmr_exp)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic; ack is checked before the timer so a last-cycle ack wins.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start && !halt) state_nxt = REQ;
      REQ:     if (mem_ack)        state_nxt = HOLD;
               else if (tmr_exp)   state_nxt = ERROR;
      HOLD:    if (instr_ready)    state_nxt = halt ? IDLE : REQ;
      ERROR:   state_nxt = ERROR;
      default: state_nxt = IDLE;
    endcase
  end

  // Captured instruction and handshake counter.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      instr       <= '0;
      fetch_count <= '0;
    end else begin
      if (in_req && mem_ack) instr <= mem_rdata;
      if (hs)                fetch_count <= fetch_count + 16'd1;
    end
  end

  // Combinational outputs are forced low while reset is asserted.
  assign mem_req     = reset_n && in_req;
  assign mem_addr    = mem_req ? pc : 16'h0000;
  assign instr_valid = reset_n && in_hold;
  assign pc_inc      = reset_n && hs;
  assign running     = reset_n && (in_req || in_hold);
  assign err         = reset_n && (state == ERROR);

endmodule
